// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types and helpers for the memory-engine command arbiter.
//   bp_me_arb_state_e        : arbiter FSM state (idle / holding a command)
//   bp_cce_mem_msg_width_lp  : default width of one bp_cce_mem_msg_s (header + data)
//   bp_me_safe_clog2         : clog2 that never returns 0, for sizing index fields
package bp_me_pkg;

  typedef enum logic {
    e_arb_idle = 1'b0,
    e_arb_send = 1'b1
  } bp_me_arb_state_e;

  localparam int bp_cce_mem_msg_width_lp = 128;

  // Index fields need at least one bit, even when there is one entry.
  function automatic int bp_me_safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_me_arb_tag_fifo.sv
// bp_me_arb_tag_fifo: records which requester owns each in-flight memory command,
// so responses (which come back in command order) can be routed to their owner.
//   clk_i, reset_i : clock, synchronous active-high reset (empties the FIFO)
//   data_i, v_i    : push tag / push strobe (ignored when full)
//   data_o         : tag at the head
//   yumi_i         : pop strobe (ignored when empty)
//   full_o, empty_o: occupancy flags
module bp_me_arb_tag_fifo
  import bp_me_pkg::*;
#(
  parameter int depth_p = 4,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w = bp_me_safe_clog2(depth_p);
  localparam int cnt_w = bp_me_safe_clog2(depth_p + 1);

  logic [width_p-1:0] mem_r [depth_p];
  logic [ptr_w-1:0]   wr_ptr_r, rd_ptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               push, pop;

  assign full_o  = (count_r == cnt_w'(depth_p));
  assign empty_o = (count_r == '0);
  assign push    = v_i & ~full_o;
  assign pop     = yumi_i & ~empty_o;
  assign data_o  = mem_r[rd_ptr_r];

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      // push and pop together leave the count unchanged
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter: round-robin arbitration of num_req_p CCE memory command
// streams onto one memory port, with in-order response routing back to the owner.
//   clk_i, reset_i            : clock, synchronous active-high reset
//   mem_cmd_i/_v_i/_yumi_o    : per-requester commands (valid->yumi), slice i at [i*msg_width_p +: msg_width_p]
//   mem_cmd_o/_v_o/_ready_i   : arbitrated command to memory (ready&valid), registered
//   mem_resp_i/_v_i/_yumi_o   : response from memory
//   mem_resp_o/_v_o/_yumi_i   : response broadcast, one-hot valid to the owning requester
//   err_o                     : sticky, set by a response with nothing in flight
// Optional: define BP_ME_MEM_ARB_TRACE_EN to log grant/response events.
module bp_me_mem_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = bp_cce_mem_msg_width_lp,
  parameter int max_outstanding_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,

  input  logic [num_req_p*msg_width_p-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]             mem_cmd_v_i,
  output logic [num_req_p-1:0]             mem_cmd_yumi_o,

  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,

  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,

  output logic [msg_width_p-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]             mem_resp_v_o,
  input  logic [num_req_p-1:0]             mem_resp_yumi_i,

  output logic                             err_o
);

  localparam int tag_w = bp_me_safe_clog2(num_req_p);

  bp_me_arb_state_e       state_r, state_n;
  logic [tag_w-1:0]       rr_ptr_r, rr_ptr_n;
  logic [msg_width_p-1:0] cmd_r;
  logic                   err_r;

  logic [tag_w-1:0]       winner;
  logic                   found;
  int                     idx;
  logic                   grant;
  logic                   send_free;

  logic [tag_w-1:0]       head_tag;
  logic                   fifo_full, fifo_empty;
  logic                   resp_ok, pop;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && mem_cmd_v_i[idx]) begin
        found  = 1'b1;
        winner = tag_w'(idx);
      end
    end
  end

  // The output register is free when empty or being drained this cycle. A pop
  // in the same cycle does not relieve a full FIFO: full is the registered count.
  assign send_free = (state_r == e_arb_idle) | mem_cmd_ready_i;
  assign grant     = ~reset_i & send_free & found & ~fifo_full;

  assign mem_cmd_yumi_o = grant ? (num_req_p'(1) << winner) : '0;
  assign rr_ptr_n       = (winner == tag_w'(num_req_p - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    state_n = state_r;
    if (grant)
      state_n = e_arb_send;
    else if (state_r == e_arb_send && mem_cmd_ready_i)
      state_n = e_arb_idle;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_arb_idle;
      rr_ptr_r <= '0;
      cmd_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      if (grant) begin
        cmd_r    <= mem_cmd_i[int'(winner)*msg_width_p +: msg_width_p];
        rr_ptr_r <= rr_ptr_n;
      end
      if (mem_resp_v_i && fifo_empty) err_r <= 1'b1;
    end
  end

  assign mem_cmd_o   = cmd_r;
  assign mem_cmd_v_o = (state_r == e_arb_send) & ~reset_i;
  assign err_o       = err_r;

  // Responses return in command order, so the FIFO head names the owner.
  assign resp_ok         = mem_resp_v_i & ~fifo_empty & ~reset_i;
  assign mem_resp_o      = mem_resp_i;
  assign mem_resp_v_o    = resp_ok ? (num_req_p'(1) << head_tag) : '0;
  assign mem_resp_yumi_o = resp_ok & mem_resp_yumi_i[head_tag];
  assign pop             = mem_resp_yumi_o;

  bp_me_arb_tag_fifo #(
    .depth_p (max_outstanding_p),
    .width_p (tag_w)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (winner),
    .v_i     (grant),
    .data_o  (head_tag),
    .yumi_i  (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef BP_ME_MEM_ARB_TRACE_EN
  bit trace_on = 1'b0;

  always @(negedge reset_i) begin
    trace_on = 1'b1;
  end

  always @(negedge clk_i) begin
    if (trace_on && !reset_i) begin
      if (grant) $display("[%0t] GRANT req[%0d]", $time, winner);
      if (pop)   $display("[%0t] RESP req[%0d]", $time, head_tag);
    end
  end
`endif

endmodule
